// File: rtl/raid_stripe.sv
// raid_stripe
//   Stripes one host command across NDRIVES drives. A host word is split
//   into NDRIVES lanes of DW bits; lane i goes to / comes from drive i.
//   Each command is broadcast to every drive with a per-drive strobe. The
//   command completes once every drive has acknowledged (busy seen high)
//   and then gone idle again (busy low). A timeout aborts a stuck command.
//
// Parameters
//   NDRIVES    : number of striped drives (must be >= 2)
//   DWIDTHHOST : host data width (must be a multiple of NDRIVES)
//   ADDRWIDTH  : host / per-drive address width
//   TMO_CYCLES : command timeout in cycles, 0 disables the timeout
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous active-high reset
//   read_en        : host read request (wins over write_en)
//   write_en       : host write request
//   host_din       : host write data
//   host_addr_in   : command address
//   host_dout      : host read data, updated only by a completed read
//   busy           : command in progress, requests ignored while high
//   done           : one-cycle completion pulse (normal or timeout)
//   error          : last command timed out, held until next accept
//   drive_busy     : per-drive busy / acknowledge
//   drive_din      : per-drive read data, lane i at [i*DW +: DW]
//   drive_dout     : per-drive write data, lane i at [i*DW +: DW]
//   drive_addr_out : per-drive address, lane i at [i*ADDRWIDTH +: ADDRWIDTH]
//   w_out          : per-drive write strobes
//   r_out          : per-drive read strobes

module raid_stripe #(
  parameter int NDRIVES    = 4,
  parameter int DWIDTHHOST = 32,
  parameter int ADDRWIDTH  = 32,
  parameter int TMO_CYCLES = 1024
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      read_en,
  input  logic                                      write_en,
  input  logic [DWIDTHHOST-1:0]                     host_din,
  input  logic [ADDRWIDTH-1:0]                      host_addr_in,
  output logic [DWIDTHHOST-1:0]                     host_dout,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      error,
  input  logic [NDRIVES-1:0]                        drive_busy,
  input  logic [NDRIVES*(DWIDTHHOST/NDRIVES)-1:0]   drive_din,
  output logic [NDRIVES*(DWIDTHHOST/NDRIVES)-1:0]   drive_dout,
  output logic [NDRIVES*ADDRWIDTH-1:0]              drive_addr_out,
  output logic [NDRIVES-1:0]                        w_out,
  output logic [NDRIVES-1:0]                        r_out
);

  localparam int DW = DWIDTHHOST / NDRIVES;

  // The counter only has to reach TMO_CYCLES-1, where it fires the timeout.
  localparam int CW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TMO_CYCLES == 0) ? 0 : TMO_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]         r_state;
  logic               r_isRead;
  logic [NDRIVES-1:0] r_ack;
  logic [CW-1:0]      r_tmoCnt;

  logic [NDRIVES-1:0] w_hit;
  logic [NDRIVES-1:0] w_ackNext;
  logic               w_timeout;
  logic               w_allIdle;

  // Only the strobe vector of the current operation is ever non-zero, so
  // OR-ing both vectors selects the active one without a mux on r_isRead.
  assign w_hit     = (r_out | w_out) & drive_busy;
  assign w_ackNext = r_ack | w_hit;
  assign w_timeout = (TMO_CYCLES != 0) && (r_tmoCnt == TMO_LAST);
  assign w_allIdle = (drive_busy == '0);

  // Command sequencer. All outputs are registered here.
  // REQ collects one acknowledge per drive (drive_busy seen high while its
  // strobe is up); WAIT then waits for every drive to drop busy again.
  // A timeout in REQ always aborts, since no completion can happen there;
  // in WAIT a simultaneous normal completion takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_isRead       <= 1'b0;
      r_ack          <= '0;
      r_tmoCnt       <= '0;
      host_dout      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      drive_dout     <= '0;
      drive_addr_out <= '0;
      w_out          <= '0;
      r_out          <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (read_en || write_en) begin
            r_isRead       <= read_en;
            drive_addr_out <= {NDRIVES{host_addr_in}};
            if (read_en) begin
              r_out <= '1;
            end else begin
              // Lane i of the host word is bits [i*DW +: DW], identical to
              // the packed drive bus layout, so a straight copy stripes it.
              drive_dout <= host_din;
              w_out      <= '1;
            end
            busy     <= 1'b1;
            error    <= 1'b0;
            r_tmoCnt <= '0;
            r_ack    <= '0;
            r_state  <= S_REQ;
          end
        end

        S_REQ: begin
          if (r_tmoCnt != '1) begin
            r_tmoCnt <= r_tmoCnt + CW'(1);
          end
          if (w_timeout) begin
            w_out   <= '0;
            r_out   <= '0;
            error   <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_ack <= w_ackNext;
            w_out <= w_out & ~w_hit;
            r_out <= r_out & ~w_hit;
            if (&w_ackNext) begin
              r_state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (r_tmoCnt != '1) begin
            r_tmoCnt <= r_tmoCnt + CW'(1);
          end
          if (w_allIdle) begin
            if (r_isRead) begin
              host_dout <= drive_din;
            end
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            w_out   <= '0;
            r_out   <= '0;
            error   <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raid_stripe.sv
// tb_raid_stripe
//   Self-checking bench for raid_stripe (NDRIVES=4, DWIDTHHOST=32,
//   TMO_CYCLES=16). A behavioural drive model answers each strobe after a
//   configurable lag and holds busy for a configurable time. Completion
//   results are queued when a command is issued and compared when done
//   pulses.

module tb_raid_stripe;

  localparam int ND  = 4;
  localparam int DWH = 32;
  localparam int AW  = 32;
  localparam int TMO = 16;

  logic              clk;
  logic              reset;
  logic              read_en;
  logic              write_en;
  logic [DWH-1:0]    host_din;
  logic [AW-1:0]     host_addr_in;
  logic [DWH-1:0]    host_dout;
  logic              busy;
  logic              done;
  logic              error;
  logic [ND-1:0]     drive_busy;
  logic [DWH-1:0]    drive_din;
  logic [DWH-1:0]    drive_dout;
  logic [ND*AW-1:0]  drive_addr_out;
  logic [ND-1:0]     w_out;
  logic [ND-1:0]     r_out;

  raid_stripe #(
    .NDRIVES(ND), .DWIDTHHOST(DWH), .ADDRWIDTH(AW), .TMO_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
    .host_din(host_din), .host_addr_in(host_addr_in), .host_dout(host_dout),
    .busy(busy), .done(done), .error(error), .drive_busy(drive_busy),
    .drive_din(drive_din), .drive_dout(drive_dout),
    .drive_addr_out(drive_addr_out), .w_out(w_out), .r_out(r_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] ddin;
    int          lag;
    int          hold;
    logic [3:0]  expW;
    logic [3:0]  expR;
    logic [31:0] expDD;
    logic [31:0] expHost;
    int          expK;
  } vec_t;

  typedef struct {
    logic [31:0] host;
    logic        err;
    int          k;
  } sb_t;

  vec_t vecs[6];
  sb_t  sb[$];

  int nCompared   = 0;
  int nMismatched = 0;

  int         lagCfg[4]  = '{0, 0, 0, 0};
  int         holdCfg    = 0;
  logic [3:0] deadCfg    = 4'b0000;
  int         lagCnt[4];
  int         holdCnt[4];

  logic [31:0] lastHost;

  // Drive model: a drive whose strobe is up raises busy after lagCfg
  // cycles, keeps it for holdCfg more cycles, then drops it. Dead drives
  // never answer.
  initial begin
    drive_busy = '0;
    for (int i = 0; i < 4; i++) begin
      lagCnt[i]  = 0;
      holdCnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (drive_busy[i]) begin
          if (holdCnt[i] == 0) drive_busy[i] = 1'b0;
          else holdCnt[i]--;
        end else if (!deadCfg[i] && (w_out[i] || r_out[i])) begin
          if (lagCnt[i] >= lagCfg[i]) begin
            drive_busy[i] = 1'b1;
            holdCnt[i]    = holdCfg;
            lagCnt[i]     = 0;
          end else begin
            lagCnt[i]++;
          end
        end else begin
          lagCnt[i] = 0;
        end
      end
    end
  end

  // Hard stop in case the bench itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives a command at the current negedge; the DUT accepts it on the
  // next posedge. Returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] din, input bit push,
                               input logic [31:0] expHost, input logic expErr, input int expK);
    sb_t e;
    read_en      = rd;
    write_en     = wr;
    host_addr_in = addr;
    host_din     = din;
    if (push) begin
      e.host = expHost;
      e.err  = expErr;
      e.k    = expK;
      sb.push_back(e);
    end
    @(negedge clk);
    read_en  = 1'b0;
    write_en = 1'b0;
  endtask

  task automatic checkAccept(input string tag, input logic [3:0] expW, input logic [3:0] expR,
                             input logic [31:0] expDD, input logic [31:0] addr);
    checkOutput({tag, " busy"}, 128'(busy), 128'(1));
    checkOutput({tag, " error"}, 128'(error), 128'(0));
    checkOutput({tag, " w_out"}, 128'(w_out), 128'(expW));
    checkOutput({tag, " r_out"}, 128'(r_out), 128'(expR));
    checkOutput({tag, " drive_dout"}, 128'(drive_dout), 128'(expDD));
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s addr_lane%0d", tag, i), 128'(drive_addr_out[i*32 +: 32]), 128'(addr));
  endtask

  // Waits (bounded) for done, compares against the oldest queued result,
  // then checks that done was a single-cycle pulse.
  task automatic finishCmd(input int k0, input string tag);
    int  k;
    bit  seen;
    sb_t e;
    k    = k0;
    seen = 0;
    while (!seen && k < k0 + 64) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) seen = 1;
    end
    if (sb.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s scoreboard: got done with empty queue expected queued result", tag);
      return;
    end
    e = sb.pop_front();
    if (!seen) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s done: got no done within %0d cycles expected done", tag, 64);
      return;
    end
    checkOutput({tag, " host_dout"}, 128'(host_dout), 128'(e.host));
    checkOutput({tag, " error"}, 128'(error), 128'(e.err));
    checkOutput({tag, " latency"}, 128'(k), 128'(e.k));
    @(negedge clk);
    checkOutput({tag, " done_pulse"}, 128'(done), 128'(0));
    checkOutput({tag, " busy_after"}, 128'(busy), 128'(0));
  endtask

  task automatic setDrives(input int l0, input int l1, input int l2, input int l3,
                           input int hold, input logic [3:0] dead);
    lagCfg[0] = l0;
    lagCfg[1] = l1;
    lagCfg[2] = l2;
    lagCfg[3] = l3;
    holdCfg   = hold;
    deadCfg   = dead;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        0, 0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0,        2};
    vecs[1] = '{1'b1, 1'b0, 32'h20,       32'h0,        32'h44332211, 0, 0, 4'h0, 4'hF, 32'hDEADBEEF, 32'h44332211, 2};
    vecs[2] = '{1'b0, 1'b1, 32'hABCD0000, 32'h12345678, 32'h0,        1, 2, 4'hF, 4'h0, 32'h12345678, 32'h44332211, 5};
    vecs[3] = '{1'b1, 1'b1, 32'h30,       32'hCAFEF00D, 32'hA5A55A5A, 2, 0, 4'h0, 4'hF, 32'h12345678, 32'hA5A55A5A, 4};
    vecs[4] = '{1'b1, 1'b0, 32'h44,       32'h0,        32'h00FF00FF, 0, 3, 4'h0, 4'hF, 32'h12345678, 32'h00FF00FF, 5};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, 0, 4'hF, 4'h0, 32'hFFFFFFFF, 32'h00FF00FF, 2};

    reset        = 1'b1;
    read_en      = 1'b0;
    write_en     = 1'b0;
    host_din     = '0;
    host_addr_in = '0;
    drive_din    = '0;
    lastHost     = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst busy", 128'(busy), 128'(0));
    checkOutput("rst done", 128'(done), 128'(0));
    checkOutput("rst error", 128'(error), 128'(0));
    checkOutput("rst host_dout", 128'(host_dout), 128'(0));
    checkOutput("rst drive_dout", 128'(drive_dout), 128'(0));
    checkOutput("rst drive_addr_out", 128'(drive_addr_out), 128'(0));
    checkOutput("rst w_out", 128'(w_out), 128'(0));
    checkOutput("rst r_out", 128'(r_out), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    // Table-driven commands with uniform drive timing.
    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      setDrives(vecs[v].lag, vecs[v].lag, vecs[v].lag, vecs[v].lag, vecs[v].hold, 4'b0000);
      drive_din = vecs[v].ddin;
      applyStimulus(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].din, 1'b1,
                    vecs[v].expHost, 1'b0, vecs[v].expK);
      checkAccept(tag, vecs[v].expW, vecs[v].expR, vecs[v].expDD, vecs[v].addr);
      finishCmd(0, tag);
      lastHost = vecs[v].expHost;
    end

    // Staggered acknowledge: drive 2 answers three cycles after the rest.
    setDrives(0, 0, 3, 0, 0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 32'h80, 32'h0BADCAFE, 1'b1, lastHost, 1'b0, 5);
    checkAccept("stagger", 4'hF, 4'h0, 32'h0BADCAFE, 32'h80);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stagger w_out c%0d", c), 128'(w_out), 128'(4'b0100));
    end
    finishCmd(3, "stagger");

    // Requests while busy are dropped, not queued.
    setDrives(0, 0, 0, 0, 4, 4'b0000);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h11112222, 1'b1, lastHost, 1'b0, 6);
    @(negedge clk);
    write_en     = 1'b1;
    read_en      = 1'b1;
    host_din     = 32'h33334444;
    host_addr_in = 32'h50;
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    checkOutput("ignore drive_dout", 128'(drive_dout), 128'(32'h11112222));
    checkOutput("ignore addr_lane0", 128'(drive_addr_out[31:0]), 128'(32'h40));
    checkOutput("ignore r_out", 128'(r_out), 128'(0));
    finishCmd(2, "ignore");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("ignore no_done c%0d", c), 128'(done), 128'(0));
    end

    // Timeout: drive 3 never answers a read.
    setDrives(0, 0, 0, 0, 0, 4'b1000);
    drive_din = 32'h99999999;
    applyStimulus(1'b1, 1'b0, 32'hA0, 32'h0, 1'b1, lastHost, 1'b1, TMO);
    checkAccept("timeout", 4'h0, 4'hF, 32'h11112222, 32'hA0);
    @(negedge clk);
    checkOutput("timeout r_out_partial", 128'(r_out), 128'(4'b1000));
    finishCmd(1, "timeout");
    checkOutput("timeout r_out_cleared", 128'(r_out), 128'(0));
    repeat (3) @(negedge clk);
    checkOutput("timeout error_held", 128'(error), 128'(1));

    // Next accepted command clears error.
    setDrives(0, 0, 0, 0, 0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 32'h90, 32'h01020304, 1'b1, lastHost, 1'b0, 2);
    checkAccept("post_tmo", 4'hF, 4'h0, 32'h01020304, 32'h90);
    finishCmd(0, "post_tmo");

    // Reset during WAIT aborts with no done pulse.
    setDrives(0, 0, 0, 0, 5, 4'b0000);
    drive_din = 32'h77777777;
    applyStimulus(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    checkOutput("rstwait busy_in_wait", 128'(busy), 128'(1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rstwait busy", 128'(busy), 128'(0));
    checkOutput("rstwait done", 128'(done), 128'(0));
    checkOutput("rstwait error", 128'(error), 128'(0));
    checkOutput("rstwait host_dout", 128'(host_dout), 128'(0));
    checkOutput("rstwait drive_dout", 128'(drive_dout), 128'(0));
    checkOutput("rstwait drive_addr_out", 128'(drive_addr_out), 128'(0));
    checkOutput("rstwait w_out", 128'(w_out), 128'(0));
    checkOutput("rstwait r_out", 128'(r_out), 128'(0));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rstwait no_done c%0d", c), 128'(done), 128'(0));
    end
    reset = 1'b0;
    setDrives(0, 0, 0, 0, 0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 32'h70, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b0, 2);
    checkAccept("after_rst", 4'hF, 4'h0, 32'h5A5A5A5A, 32'h70);
    finishCmd(0, "after_rst");

    if (sb.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
